glb_stream_reader: RTL and testbench

- Downstream consumer of the GLB. Once the DMA has filled the GLB, this block reads a byte range from it sequentially and packs the bytes into 32-bit little-endian words.
- Words go out on a valid/ready stream toward the PE-array input.
- A small output FIFO absorbs PE backpressure, so GLB reads stall cleanly and no byte is lost.

---
 rtl/glb_stream_pkg.sv | 26 ++
 rtl/sync_word_fifo.sv | 54 +++++
 rtl/glb_stream_reader.sv | 148 ++++++++++++++
 tb/tb_glb_stream_reader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glb_stream_pkg.sv
// Shared types for the GLB stream reader: FSM states, the FIFO word record
// and the byte-lane keep helper.
package glb_stream_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_WIDTH     = 32;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } state_t;

   typedef struct packed {
      logic [WORD_WIDTH-1:0]     data;
      logic [BYTES_PER_WORD-1:0] keep;
      logic                      last;
   } fifo_entry_t;

   // Lanes 0..lane are valid in a word whose highest filled lane is 'lane'.
   function automatic logic [BYTES_PER_WORD-1:0] keep_mask(input logic [1:0] lane);
      return 4'b1111 >> (2'd3 - lane);
   endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Small synchronous FIFO of packed stream words with an occupancy count;
// a push and a pop in the same cycle leave the count unchanged.
module sync_word_fifo
   import glb_stream_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  fifo_entry_t              push_data,
   input  logic                     pop,
   output fifo_entry_t              head,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fifo_entry_t      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage carries no reset; the reader masks the head while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/glb_stream_reader.sv
// Reads a byte range from the GLB and packs it into 32-bit little-endian stream words.
// Optional macro GLB_STREAM_STRIDE_EN adds a per-transfer address stride input.
module glb_stream_reader
   import glb_stream_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int GLB_DATA_WIDTH = 8,
   parameter int OUT_WIDTH      = 32,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [ADDR_WIDTH-1:0]     base_addr,
   input  logic [15:0]               length,
`ifdef GLB_STREAM_STRIDE_EN
   input  logic [15:0]               stride,
`endif
   output logic                      busy,
   output logic                      done,
   output logic                      glb_re,
   output logic [ADDR_WIDTH-1:0]     glb_r_addr,
   input  logic [GLB_DATA_WIDTH-1:0] glb_dout,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [OUT_WIDTH-1:0]      out_data,
   output logic [3:0]                out_keep,
   output logic                      out_last
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_t                state;
   state_t                state_next;
   logic [15:0]           len_r;
   logic [16:0]           issue_cnt;
   logic [16:0]           pack_cnt;
   logic [ADDR_WIDTH-1:0] addr_acc;
   logic [ADDR_WIDTH-1:0] addr_step;
   logic                  in_flight;
   logic [OUT_WIDTH-1:0]  pack_reg;
   logic [OUT_WIDTH-1:0]  pack_merged;
   logic [1:0]            lane;
   logic                  final_byte;
   logic                  issue_done;
   logic                  accept_start;
   logic                  push;
   logic                  pop;
   fifo_entry_t           push_entry;
   fifo_entry_t           head;
   logic                  fifo_empty;
   logic [CNT_W-1:0]      fifo_count;

`ifdef GLB_STREAM_STRIDE_EN
   logic [15:0] stride_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                           stride_r <= '0;
      else if (state == IDLE && start)   stride_r <= stride;
   end

   assign addr_step = ADDR_WIDTH'(stride_r);
`else
   assign addr_step = ADDR_WIDTH'(1);
`endif

   assign accept_start = (state == IDLE) && start;
   assign issue_done   = (issue_cnt == {1'b0, len_r});
   // One slot stays free so a word completed by the in-flight byte always fits.
   assign glb_re       = (state == READ) && !issue_done &&
                         (fifo_count < CNT_W'(FIFO_DEPTH - 1));
   assign glb_r_addr   = addr_acc;

   assign lane       = pack_cnt[1:0];
   assign final_byte = ((pack_cnt + 17'd1) == {1'b0, len_r});
   assign push       = in_flight && ((lane == 2'd3) || final_byte);

   always_comb begin
      pack_merged = pack_reg;
      pack_merged[lane*GLB_DATA_WIDTH +: GLB_DATA_WIDTH] = glb_dout;
   end

   assign push_entry = '{data: pack_merged, keep: keep_mask(lane), last: final_byte};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         len_r     <= '0;
         issue_cnt <= '0;
         pack_cnt  <= '0;
         addr_acc  <= '0;
         in_flight <= 1'b0;
         pack_reg  <= '0;
      end else begin
         state     <= state_next;
         in_flight <= glb_re;
         if (accept_start) begin
            len_r     <= length;
            issue_cnt <= '0;
            pack_cnt  <= '0;
            addr_acc  <= base_addr;
            pack_reg  <= '0;
         end else begin
            if (glb_re) begin
               issue_cnt <= issue_cnt + 17'd1;
               addr_acc  <= addr_acc + addr_step;
            end
            if (in_flight) begin
               pack_cnt <= pack_cnt + 17'd1;
               pack_reg <= push ? '0 : pack_merged;
            end
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = (length == 16'd0) ? DONE : READ;
         READ:    if (issue_done) state_next = DRAIN;
         DRAIN:   if (!in_flight && fifo_empty) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   sync_word_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign pop       = out_valid && out_ready;
   assign out_valid = !fifo_empty;
   assign out_data  = out_valid ? head.data : '0;
   assign out_keep  = out_valid ? head.keep : '0;
   assign out_last  = out_valid && head.last;
   assign busy      = (state == READ) || (state == DRAIN);
   assign done      = (state == DONE);

endmodule

// File: tb/tb_glb_stream_reader.sv
// Self-checking bench for glb_stream_reader: GLB byte model, word scoreboard,
// table of transfers plus hand-written reset, backpressure and zero-length cases.
module tb_glb_stream_reader;
   import glb_stream_pkg::*;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [15:0]   length;
`ifdef GLB_STREAM_STRIDE_EN
   logic [15:0]   stride;
`endif
   logic          busy;
   logic          done;
   logic          glb_re;
   logic [AW-1:0] glb_r_addr;
   logic [7:0]    glb_dout;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_data;
   logic [3:0]    out_keep;
   logic          out_last;

   always #5 clk = ~clk;

   glb_stream_reader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .length     (length),
`ifdef GLB_STREAM_STRIDE_EN
      .stride     (stride),
`endif
      .busy       (busy),
      .done       (done),
      .glb_re     (glb_re),
      .glb_r_addr (glb_r_addr),
      .glb_dout   (glb_dout),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_keep   (out_keep),
      .out_last   (out_last)
   );

   typedef struct {
      logic [31:0] base;
      logic [15:0] len;
      logic        rand_ready;
      int          exp_words;
      logic [3:0]  exp_last_keep;
      logic [31:0] exp_last_data;
   } vec_t;

   int            total = 0;
   int            bad = 0;
   fifo_entry_t   exp_q[$];
   logic [AW-1:0] addr_q[$];
   logic [AW-1:0] glb_base = '0;
   int            cyc = 0;
   int            reads = 0;
   int            words = 0;
   int            done_cnt = 0;
   int            lat_target = 0;
   int            nth_issue_cyc = -1;
   int            first_valid_cyc = -1;
   logic          valid_seen = 1'b0;
   logic          rand_ready = 1'b0;
   logic [31:0]   last_data = '0;
   logic [3:0]    last_keep = '0;
   logic          hold_valid = 1'b0;
   logic [36:0]   held = '0;
   vec_t          vecs[7];

   // GLB content: the byte at the transfer base reads 1, the next address 2, and so on.
   function automatic logic [7:0] glb_byte(input logic [AW-1:0] a);
      logic [AW-1:0] d;
      d = a - glb_base + 1;
      return d[7:0];
   endfunction

   always @(posedge clk) glb_dout <= glb_re ? glb_byte(glb_r_addr) : 8'hEE;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   // Monitor: address checks, scoreboard pops, hold stability, done pulses.
   initial begin
      fifo_entry_t   e;
      logic [AW-1:0] a;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_valid = 1'b0;
         end else begin
            cyc++;
            if (glb_re) begin
               reads++;
               if (addr_q.size() == 0) check_output("unexpected_glb_re", 64'(1), 64'(0));
               else begin
                  a = addr_q.pop_front();
                  check_output("glb_r_addr", 64'(glb_r_addr), 64'(a));
               end
               if (reads == lat_target) nth_issue_cyc = cyc;
            end
            if (out_valid) begin
               valid_seen = 1'b1;
               if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (hold_valid)
               check_output("hold_stable", 64'({out_valid, out_data, out_keep, out_last}),
                            64'({1'b1, held}));
            if (out_valid && out_ready) begin
               words++;
               if (exp_q.size() == 0) check_output("unexpected_word", 64'(1), 64'(0));
               else begin
                  e = exp_q.pop_front();
                  check_output("word", 64'({out_data, out_keep, out_last}),
                               64'({e.data, e.keep, e.last}));
               end
               if (out_last) begin
                  last_data = out_data;
                  last_keep = out_keep;
               end
            end
            hold_valid = out_valid && !out_ready;
            held       = {out_data, out_keep, out_last};
            if (done) begin
               done_cnt++;
               check_output("busy_in_done", 64'(busy), 64'(0));
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Loads the expected addresses and words, then pulses start for one cycle.
   task automatic apply_stimulus(input logic [AW-1:0] base, input logic [15:0] len,
                                 input logic [15:0] strd);
      fifo_entry_t e;
      int          nw;
      int          k;
      glb_base        = base;
      reads           = 0;
      words           = 0;
      done_cnt        = 0;
      nth_issue_cyc   = -1;
      first_valid_cyc = -1;
      valid_seen      = 1'b0;
      lat_target      = (len < 4) ? int'(len) : 4;
      nw              = (int'(len) + 3) / 4;
      for (int i = 0; i < int'(len); i++) addr_q.push_back(base + AW'(i) * AW'(strd));
      for (int w = 0; w < nw; w++) begin
         e = '0;
         for (int i = 0; i < 4; i++) begin
            k = 4 * w + i;
            if (k < int'(len)) begin
               e.data[8*i +: 8] = glb_byte(base + AW'(k) * AW'(strd));
               e.keep[i]        = 1'b1;
            end
         end
         e.last = (w == nw - 1);
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = base;
      length    = len;
`ifdef GLB_STREAM_STRIDE_EN
      stride    = strd;
`endif
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input logic [15:0] len, input int limit);
      for (int i = 0; i < limit && done_cnt == 0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      check_output("done_pulses", 64'(done_cnt), 64'(1));
      check_output("words_left", 64'(exp_q.size()), 64'(0));
      check_output("read_count", 64'(reads), 64'(len));
      check_output("busy_after_done", 64'(busy), 64'(0));
      if (len != 0)
         check_output("first_valid_latency", 64'(first_valid_cyc - nth_issue_cyc), 64'(2));
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      bad++;
      total++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
`ifdef GLB_STREAM_STRIDE_EN
      stride    = 16'd1;
`endif
      out_ready = 1'b1;

      vecs[0] = '{32'h0000_0010, 16'd8,  1'b0, 2, 4'hF, 32'h0807_0605};
      vecs[1] = '{32'h0000_0000, 16'd6,  1'b0, 2, 4'h3, 32'h0000_0605};
      vecs[2] = '{32'h0000_0020, 16'd1,  1'b0, 1, 4'h1, 32'h0000_0001};
      vecs[3] = '{32'h0000_0100, 16'd7,  1'b1, 2, 4'h7, 32'h0007_0605};
      vecs[4] = '{32'hFFFF_FFFE, 16'd9,  1'b1, 3, 4'h1, 32'h0000_0009};
      vecs[5] = '{32'h0000_0040, 16'd4,  1'b0, 1, 4'hF, 32'h0403_0201};
      vecs[6] = '{32'h0000_0007, 16'd13, 1'b1, 4, 4'h1, 32'h0000_000D};

      repeat (2) @(posedge clk);
      #1;
      check_output("reset_outputs",
                   64'({busy, done, glb_re, out_valid, out_last, out_keep}), 64'(0));
      check_output("reset_addr", 64'(glb_r_addr), 64'(0));
      check_output("reset_data", 64'(out_data), 64'(0));
      rst = 1'b0;

      for (int v = 0; v < 7; v++) begin
         rand_ready = vecs[v].rand_ready;
         out_ready  = 1'b1;
         apply_stimulus(vecs[v].base, vecs[v].len, 16'd1);
         check_output("busy_after_start", 64'(busy), 64'(1));
         wait_done(vecs[v].len, 400);
         rand_ready = 1'b0;
         out_ready  = 1'b1;
         check_output("word_count", 64'(words), 64'(vecs[v].exp_words));
         check_output("last_keep", 64'(last_keep), 64'(vecs[v].exp_last_keep));
         check_output("last_data", 64'(last_data), 64'(vecs[v].exp_last_data));
      end

      // Zero-length transfer: done one cycle after acceptance, no reads or words.
      apply_stimulus(32'h50, 16'd0, 16'd1);
      @(posedge clk);
      check_output("len0_done_by_2", 64'(done_cnt), 64'(1));
      repeat (5) @(posedge clk);
      check_output("len0_done_once", 64'(done_cnt), 64'(1));
      check_output("len0_no_reads", 64'(reads), 64'(0));
      check_output("len0_no_valid", 64'(valid_seen), 64'(0));

      // Backpressure with an ignored start pulse while busy.
      out_ready = 1'b0;
      apply_stimulus(32'h200, 16'd32, 16'd1);
      repeat (5) @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = 32'h999;
      length    = 16'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (13) @(posedge clk);
      #1;
      check_output("stall_reads", 64'(reads), 64'(13));
      check_output("stall_glb_re_low", 64'(glb_re), 64'(0));
      check_output("stall_valid", 64'(out_valid), 64'(1));
      check_output("stall_no_words", 64'(words), 64'(0));
      out_ready = 1'b1;
      wait_done(16'd32, 400);
      check_output("stall_word_count", 64'(words), 64'(8));

      // Asynchronous reset after the fifth byte of a 16-byte transfer.
      apply_stimulus(32'h300, 16'd16, 16'd1);
      for (int i = 0; i < 50 && reads < 5; i++) @(posedge clk);
      check_output("reached_byte5", 64'(reads >= 5), 64'(1));
      #2;
      rst = 1'b1;
      #1;
      check_output("abort_outputs",
                   64'({busy, done, glb_re, out_valid, out_last, out_keep}), 64'(0));
      check_output("abort_addr_data", 64'({glb_r_addr, out_data}), 64'(0));
      exp_q.delete();
      addr_q.delete();
      done_cnt = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      check_output("abort_no_done", 64'(done_cnt), 64'(0));
      apply_stimulus(32'h0, 16'd6, 16'd1);
      wait_done(16'd6, 400);
      check_output("after_abort_last", 64'({last_data, last_keep}), 64'({32'h0000_0605, 4'h3}));

`ifdef GLB_STREAM_STRIDE_EN
      apply_stimulus(32'h0, 16'd4, 16'd4);
      wait_done(16'd4, 400);
      check_output("stride_word", 64'({last_data, last_keep}), 64'({32'h0D09_0501, 4'hF}));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
